// File: rtl/multibyte_add_seq.sv
// Multi-byte add/subtract sequencer: drives one external 8-bit ripple-carry adder
// one byte per clock (LSB first), chaining the carry through a register.
module multibyte_add_seq #(
    parameter int BYTES = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iSub,
    input  logic [8*BYTES-1:0] iA,
    input  logic [8*BYTES-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [8*BYTES-1:0] oSum,
    output logic             oCarry,
    output logic             oOverflow,
    output logic [7:0]       oAdd_a,
    output logic [7:0]       oAdd_b,
    output logic             oAdd_c,
    input  logic [7:0]       iAdd_s,
    input  logic             iAdd_c
);

    localparam int W    = 8 * BYTES;
    localparam int IW   = $clog2(BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           c_q, c_d;
    logic [IW-1:0]  idx_q, idx_d;
    // Lower result bytes collect here so oSum only moves on the final byte.
    logic [W-9:0]   acc_q, acc_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           carry_q, carry_d;
    logic           ovf_q, ovf_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    a_d     = iA;
                    b_d     = iSub ? ~iB : iB;
                    c_d     = iSub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                c_d = iAdd_c;
                if (idx_q == LAST_IDX) begin
                    sum_d   = {iAdd_s, acc_q};
                    carry_d = iAdd_c;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (iAdd_s[7] != a_q[W-1]);
                    state_d = ST_DONE;
                end else begin
                    for (int i = 0; i < BYTES - 1; i++) begin
                        if (idx_q == IW'(i)) begin
                            acc_d[8*i +: 8] = iAdd_s;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge iClk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (iRst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Adder operands are combinational from the registered state, zero outside RUN.
    always_comb begin
        oAdd_a = '0;
        oAdd_b = '0;
        oAdd_c = 1'b0;
        if (state_q == ST_RUN) begin
            oAdd_a = a_q[8*idx_q +: 8];
            oAdd_b = b_q[8*idx_q +: 8];
            oAdd_c = c_q;
        end
    end

    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oSum      = sum_q;
    assign oCarry    = carry_q;
    assign oOverflow = ovf_q;

endmodule
